coherence_ctrl: RTL and testbench

Bus and coherence controller between the two cores' L1 caches and the single-ported RAM. Arbitrates instruction fetches, data fills and write-backs from both cores, and runs MSI snoop transactions between the two dcaches. On a dirty remote hit it forwards the block cache-to-cache while writing it back to RAM. It is the stage directly downstream of each dcache's miss, flush and snoop state machine.

---
 rtl/coherence_ctrl_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/coherence_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_coherence_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/coherence_ctrl_pkg.sv
// Shared types for the two-core bus/coherence controller: RAM handshake,
// bus word and the controller's transaction states.
package coherence_ctrl_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'b00,
    BUSY   = 2'b01,
    ACCESS = 2'b10,
    ERROR  = 2'b11
  } ramstate_t;

  typedef enum logic [3:0] {
    IDLE,
    ARB,
    SNOOP,
    LOAD1,
    LOAD2,
    XFER1,
    XFER2,
    WB,
    IFETCH
  } ccstate_t;

endpackage

// File: rtl/rr_arbiter.sv
// Two-way round-robin picker; the pointer moves to the losing core once the
// granted transaction has completed.
module rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       grant_i,
  input  logic       advance_i,
  output logic       pick_o,
  output logic       valid_o
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) ptr_d = ~grant_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

  always_comb begin
    valid_o = |req_i;
    case (req_i)
      2'b01:   pick_o = 1'b0;
      2'b10:   pick_o = 1'b1;
      default: pick_o = ptr_q;
    endcase
  end

endmodule

// File: rtl/coherence_ctrl.sv
// Bus and MSI coherence controller between two L1 cache pairs and one
// single-ported RAM, with cache-to-cache forwarding on a dirty remote hit.
module coherence_ctrl
  import coherence_ctrl_pkg::*;
#(
  parameter int CPUS = 2
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [CPUS-1:0] iREN,
  input  word_t           iaddr [CPUS],
  output logic [CPUS-1:0] iwait,
  output word_t           iload,
  input  logic [CPUS-1:0] dREN,
  input  logic [CPUS-1:0] dWEN,
  input  word_t           daddr [CPUS],
  input  word_t           dstore [CPUS],
  output logic [CPUS-1:0] dwait,
  output word_t           dload [CPUS],
  input  logic [CPUS-1:0] cctrans,
  input  logic [CPUS-1:0] ccwrite,
  output logic [CPUS-1:0] ccwait,
  output logic [CPUS-1:0] ccinv,
  output word_t           ccsnoopaddr [CPUS],
  input  ramstate_t       ramstate,
  input  word_t           ramload,
  output logic            ramREN,
  output logic            ramWEN,
  output word_t           ramaddr,
  output word_t           ramstore
);

  ccstate_t        state_q, state_d;
  logic            rIdx_q, rIdx_d;
  logic            sIdx;
  logic            access;
  logic            anyReq;
  logic            xferHeld;
  logic            advance;
  logic            pick;
  logic            arbValid;
  logic [CPUS-1:0] wbReq;
  logic [CPUS-1:0] arbReq;

  assign sIdx     = ~rIdx_q;
  assign access   = (ramstate == ACCESS);
  assign anyReq   = |{iREN, dREN, dWEN, cctrans};
  assign xferHeld = dREN[rIdx_q] & dWEN[sIdx];

  // Write-backs outrank coherence misses, which outrank instruction fetches.
  always_comb begin
    wbReq = dWEN & ~cctrans;
    if (|wbReq)        arbReq = wbReq;
    else if (|cctrans) arbReq = cctrans;
    else               arbReq = iREN;
  end

  rr_arbiter u_arb (
    .clk       (CLK),
    .rst_n     (nRST),
    .req_i     (arbReq),
    .grant_i   (rIdx_q),
    .advance_i (advance),
    .pick_o    (pick),
    .valid_o   (arbValid)
  );

  always_comb begin
    state_d = state_q;
    rIdx_d  = rIdx_q;
    advance = 1'b0;
    case (state_q)
      IDLE: if (anyReq) state_d = ARB;
      ARB: begin
        if (arbValid) begin
          rIdx_d = pick;
          if (|wbReq)        state_d = WB;
          else if (|cctrans) state_d = SNOOP;
          else               state_d = IFETCH;
        end else begin
          state_d = IDLE;
        end
      end
      WB: begin
        if (!dWEN[rIdx_q]) state_d = IDLE;
        else if (access) begin
          state_d = IDLE;
          advance = 1'b1;
        end
      end
      IFETCH: begin
        if (!iREN[rIdx_q]) state_d = IDLE;
        else if (access) begin
          state_d = IDLE;
          advance = 1'b1;
        end
      end
      SNOOP: begin
        if (!dREN[rIdx_q])     state_d = IDLE;
        else if (cctrans[sIdx]) state_d = XFER1;
        else                    state_d = LOAD1;
      end
      LOAD1: begin
        if (!dREN[rIdx_q]) state_d = IDLE;
        else if (access)   state_d = LOAD2;
      end
      LOAD2: begin
        if (!dREN[rIdx_q]) state_d = IDLE;
        else if (access) begin
          state_d = IDLE;
          advance = 1'b1;
        end
      end
      XFER1: begin
        if (!xferHeld)   state_d = IDLE;
        else if (access) state_d = XFER2;
      end
      XFER2: begin
        if (!xferHeld) state_d = IDLE;
        else if (access) begin
          state_d = IDLE;
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      rIdx_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rIdx_q  <= rIdx_d;
    end
  end

  // Strobes are gated by the held request so a dropped request never reaches RAM.
  always_comb begin
    iwait    = '1;
    dwait    = '1;
    ccwait   = '0;
    ccinv    = '0;
    iload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    for (int n = 0; n < CPUS; n++) begin
      dload[n]       = '0;
      ccsnoopaddr[n] = '0;
    end
    case (state_q)
      WB: begin
        if (dWEN[rIdx_q]) begin
          ramWEN        = 1'b1;
          ramaddr       = daddr[rIdx_q];
          ramstore      = dstore[rIdx_q];
          dwait[rIdx_q] = ~access;
        end
      end
      IFETCH: begin
        if (iREN[rIdx_q]) begin
          ramREN        = 1'b1;
          ramaddr       = iaddr[rIdx_q];
          iload         = ramload;
          iwait[rIdx_q] = ~access;
        end
      end
      SNOOP: begin
        ccwait[sIdx]      = 1'b1;
        ccsnoopaddr[sIdx] = daddr[rIdx_q];
        ccinv[sIdx]       = ccwrite[rIdx_q];
      end
      LOAD1, LOAD2: begin
        if (dREN[rIdx_q]) begin
          ramREN        = 1'b1;
          ramaddr       = daddr[rIdx_q];
          dload[rIdx_q] = ramload;
          dwait[rIdx_q] = ~access;
        end
      end
      XFER1, XFER2: begin
        ccwait[sIdx]      = 1'b1;
        ccsnoopaddr[sIdx] = daddr[rIdx_q];
        ccinv[sIdx]       = ccwrite[rIdx_q];
        if (xferHeld) begin
          ramWEN        = 1'b1;
          ramaddr       = daddr[sIdx];
          ramstore      = dstore[sIdx];
          dload[rIdx_q] = dstore[sIdx];
          dwait[rIdx_q] = ~access;
          dwait[sIdx]   = ~access;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_coherence_ctrl.sv
// Directed bench for coherence_ctrl: a small latency-2 RAM model plus
// hand-computed cycle-by-cycle expectations per scenario.
module tb_coherence_ctrl;
  import coherence_ctrl_pkg::*;

  localparam int LAT = 2;

  logic       CLK;
  logic       nRST;
  logic [1:0] iREN, dREN, dWEN, cctrans, ccwrite;
  word_t      iaddr [2];
  word_t      daddr [2];
  word_t      dstore [2];
  logic [1:0] iwait, dwait, ccwait, ccinv;
  word_t      iload;
  word_t      dload [2];
  word_t      ccsnoopaddr [2];
  ramstate_t  ramstate;
  word_t      ramload;
  logic       ramREN, ramWEN;
  word_t      ramaddr, ramstore;

  int    checks   = 0;
  int    failures = 0;
  int    latCnt;
  logic  errInject = 1'b0;
  int    wrCount;
  word_t wrAddr [16];
  word_t wrData [16];

  coherence_ctrl #(.CPUS(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .cctrans(cctrans), .ccwrite(ccwrite), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramstate(ramstate), .ramload(ramload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM model: fixed latency, read data is a recognisable function of the address
  assign ramstate = errInject ? ERROR :
                    (ramREN || ramWEN) ? ((latCnt >= LAT-1) ? ACCESS : BUSY) : FREE;
  assign ramload  = ramaddr ^ 32'hA5A5_0000;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      latCnt  <= 0;
      wrCount <= 0;
    end else begin
      if ((ramREN || ramWEN) && ramstate != ACCESS) latCnt <= latCnt + 1;
      else                                          latCnt <= 0;
      if (ramWEN && ramstate == ACCESS) begin
        wrAddr[wrCount % 16] <= ramaddr;
        wrData[wrCount % 16] <= ramstore;
        wrCount              <= wrCount + 1;
      end
    end
  end

  task automatic clearInputs;
    iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    for (int n = 0; n < 2; n++) begin
      iaddr[n] = '0; daddr[n] = '0; dstore[n] = '0;
    end
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    clearInputs();
    @(negedge CLK); #1;
    checks++; if (iwait !== 2'b11) begin failures++; $display("[TB] FAIL reset_iwait got=%b exp=11", iwait); end
    checks++; if (dwait !== 2'b11) begin failures++; $display("[TB] FAIL reset_dwait got=%b exp=11", dwait); end
    checks++; if ({ccwait, ccinv} !== 4'b0000) begin failures++; $display("[TB] FAIL reset_cc got=%b exp=0000", {ccwait, ccinv}); end
    checks++; if ({ramREN, ramWEN} !== 2'b00) begin failures++; $display("[TB] FAIL reset_ramstrobe got=%b exp=00", {ramREN, ramWEN}); end
    checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin failures++; $display("[TB] FAIL reset_ramaddr got=%h/%h exp=0/0", ramaddr, ramstore); end
    checks++; if (iload !== 32'h0 || dload[0] !== 32'h0 || dload[1] !== 32'h0) begin failures++; $display("[TB] FAIL reset_loads got=%h/%h/%h exp=0", iload, dload[0], dload[1]); end
    checks++; if (ccsnoopaddr[0] !== 32'h0 || ccsnoopaddr[1] !== 32'h0) begin failures++; $display("[TB] FAIL reset_snoopaddr got=%h/%h exp=0", ccsnoopaddr[0], ccsnoopaddr[1]); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("[TB] FAIL reset_state got=%0d exp=IDLE", dut.state_q); end
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_fill;
    @(negedge CLK);
    dREN[0] = 1'b1; cctrans[0] = 1'b1; ccwrite[0] = 1'b0; daddr[0] = 32'h100;
    @(negedge CLK); #1;
    checks++; if (ramREN !== 1'b0) begin failures++; $display("[TB] FAIL fill_arb_ramREN got=%b exp=0", ramREN); end
    @(negedge CLK); #1;
    checks++; if (ccwait !== 2'b10) begin failures++; $display("[TB] FAIL fill_snoop_ccwait got=%b exp=10", ccwait); end
    checks++; if (ccsnoopaddr[1] !== 32'h100) begin failures++; $display("[TB] FAIL fill_snoopaddr got=%h exp=100", ccsnoopaddr[1]); end
    checks++; if (ccinv !== 2'b00) begin failures++; $display("[TB] FAIL fill_ccinv got=%b exp=00", ccinv); end
    @(negedge CLK); #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100 || dwait !== 2'b11) begin failures++; $display("[TB] FAIL fill_w0_busy got=%b/%h/%b exp=1/100/11", ramREN, ramaddr, dwait); end
    @(negedge CLK); #1;
    checks++; if (dwait !== 2'b10 || dload[0] !== 32'hA5A5_0100) begin failures++; $display("[TB] FAIL fill_w0_access got=%b/%h exp=10/a5a50100", dwait, dload[0]); end
    @(negedge CLK);
    daddr[0] = 32'h104; #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h104 || dwait !== 2'b11) begin failures++; $display("[TB] FAIL fill_w1_busy got=%b/%h/%b exp=1/104/11", ramREN, ramaddr, dwait); end
    @(negedge CLK); #1;
    checks++; if (dwait !== 2'b10 || dload[0] !== 32'hA5A5_0104) begin failures++; $display("[TB] FAIL fill_w1_access got=%b/%h exp=10/a5a50104", dwait, dload[0]); end
    @(negedge CLK);
    clearInputs(); #1;
    checks++; if (dut.state_q !== IDLE || ramREN !== 1'b0) begin failures++; $display("[TB] FAIL fill_done got=%0d/%b exp=IDLE/0", dut.state_q, ramREN); end
  endtask

  task automatic test_dirty_hit;
    int startW;
    @(negedge CLK);
    startW = wrCount;
    dREN[1] = 1'b1; cctrans[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h200;
    @(negedge CLK);
    @(negedge CLK); #1;
    checks++; if (ccwait !== 2'b01 || ccinv !== 2'b01) begin failures++; $display("[TB] FAIL dirty_snoop got=%b/%b exp=01/01", ccwait, ccinv); end
    checks++; if (ccsnoopaddr[0] !== 32'h200) begin failures++; $display("[TB] FAIL dirty_snoopaddr got=%h exp=200", ccsnoopaddr[0]); end
    cctrans[0] = 1'b1; dWEN[0] = 1'b1; daddr[0] = 32'h200; dstore[0] = 32'hDEAD;
    @(negedge CLK); #1;
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h200 || ramstore !== 32'hDEAD) begin failures++; $display("[TB] FAIL dirty_w0_ram got=%b%b/%h/%h exp=10/200/dead", ramWEN, ramREN, ramaddr, ramstore); end
    checks++; if (dload[1] !== 32'hDEAD || dwait !== 2'b11) begin failures++; $display("[TB] FAIL dirty_w0_busy got=%h/%b exp=dead/11", dload[1], dwait); end
    @(negedge CLK); #1;
    checks++; if (dwait !== 2'b00) begin failures++; $display("[TB] FAIL dirty_w0_access got=%b exp=00", dwait); end
    @(negedge CLK);
    daddr[0] = 32'h204; dstore[0] = 32'hBEEF; daddr[1] = 32'h204; #1;
    checks++; if (ramaddr !== 32'h204 || dload[1] !== 32'hBEEF || ramREN !== 1'b0 || dwait !== 2'b11) begin failures++; $display("[TB] FAIL dirty_w1_busy got=%h/%h/%b/%b exp=204/beef/0/11", ramaddr, dload[1], ramREN, dwait); end
    @(negedge CLK); #1;
    checks++; if (dwait !== 2'b00 || ramstore !== 32'hBEEF) begin failures++; $display("[TB] FAIL dirty_w1_access got=%b/%h exp=00/beef", dwait, ramstore); end
    @(negedge CLK);
    clearInputs(); #1;
    checks++; if (wrCount - startW !== 2) begin failures++; $display("[TB] FAIL dirty_wr_count got=%0d exp=2", wrCount - startW); end
    checks++; if (wrAddr[startW % 16] !== 32'h200 || wrData[startW % 16] !== 32'hDEAD || wrAddr[(startW+1) % 16] !== 32'h204 || wrData[(startW+1) % 16] !== 32'hBEEF) begin
      failures++; $display("[TB] FAIL dirty_wr_log got=%h:%h %h:%h exp=200:dead 204:beef", wrAddr[startW % 16], wrData[startW % 16], wrAddr[(startW+1) % 16], wrData[(startW+1) % 16]);
    end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("[TB] FAIL dirty_done got=%0d exp=IDLE", dut.state_q); end
  endtask

  task automatic test_contention;
    @(negedge CLK); nRST = 1'b0;
    @(negedge CLK); nRST = 1'b1;
    @(negedge CLK);
    iREN = 2'b11; iaddr[0] = 32'h400; iaddr[1] = 32'h800;
    @(negedge CLK);
    @(negedge CLK); #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h400 || iwait !== 2'b11) begin failures++; $display("[TB] FAIL tie1_busy got=%b/%h/%b exp=1/400/11", ramREN, ramaddr, iwait); end
    @(negedge CLK); #1;
    checks++; if (iwait !== 2'b10 || iload !== 32'hA5A5_0400) begin failures++; $display("[TB] FAIL tie1_access got=%b/%h exp=10/a5a50400", iwait, iload); end
    @(negedge CLK);
    iaddr[0] = 32'h404; #1;
    checks++; if (iwait !== 2'b11) begin failures++; $display("[TB] FAIL tie_gap_iwait got=%b exp=11", iwait); end
    @(negedge CLK);
    @(negedge CLK); #1;
    checks++; if (ramaddr !== 32'h800 || iwait !== 2'b11) begin failures++; $display("[TB] FAIL tie2_busy got=%h/%b exp=800/11", ramaddr, iwait); end
    @(negedge CLK); #1;
    checks++; if (iwait !== 2'b01 || iload !== 32'hA5A5_0800) begin failures++; $display("[TB] FAIL tie2_access got=%b/%h exp=01/a5a50800", iwait, iload); end
    @(negedge CLK);
    iaddr[1] = 32'h804;
    @(negedge CLK);
    @(negedge CLK); #1;
    checks++; if (ramaddr !== 32'h404 || iwait !== 2'b11) begin failures++; $display("[TB] FAIL tie3_busy got=%h/%b exp=404/11", ramaddr, iwait); end
    @(negedge CLK); #1;
    checks++; if (iwait !== 2'b10) begin failures++; $display("[TB] FAIL tie3_access got=%b exp=10", iwait); end
    @(negedge CLK);
    clearInputs(); #1;
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("[TB] FAIL tie_done got=%0d exp=IDLE", dut.state_q); end
  endtask

  task automatic test_eviction;
    @(negedge CLK);
    dWEN[0] = 1'b1; daddr[0] = 32'h300; dstore[0] = 32'h1234_5678;
    iREN[1] = 1'b1; iaddr[1] = 32'h900;
    @(negedge CLK);
    @(negedge CLK); #1;
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h300 || ramstore !== 32'h1234_5678) begin failures++; $display("[TB] FAIL evict_wb got=%b%b/%h/%h exp=10/300/12345678", ramWEN, ramREN, ramaddr, ramstore); end
    checks++; if (iwait !== 2'b11) begin failures++; $display("[TB] FAIL evict_iwait got=%b exp=11", iwait); end
    @(negedge CLK); #1;
    checks++; if (dwait !== 2'b10) begin failures++; $display("[TB] FAIL evict_access got=%b exp=10", dwait); end
    @(negedge CLK);
    dWEN[0] = 1'b0;
    @(negedge CLK);
    @(negedge CLK); #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h900) begin failures++; $display("[TB] FAIL evict_ifetch got=%b/%h exp=1/900", ramREN, ramaddr); end
    @(negedge CLK); #1;
    checks++; if (iwait !== 2'b01 || iload !== 32'hA5A5_0900) begin failures++; $display("[TB] FAIL evict_ifetch_access got=%b/%h exp=01/a5a50900", iwait, iload); end
    @(negedge CLK);
    clearInputs();
  endtask

  task automatic test_ram_error;
    @(negedge CLK);
    errInject = 1'b1;
    dWEN[1] = 1'b1; daddr[1] = 32'h310; dstore[1] = 32'hCAFE;
    @(negedge CLK);
    @(negedge CLK); #1;
    checks++; if (ramWEN !== 1'b1 || dwait !== 2'b11) begin failures++; $display("[TB] FAIL err_hold1 got=%b/%b exp=1/11", ramWEN, dwait); end
    @(negedge CLK); #1;
    checks++; if (dwait !== 2'b11) begin failures++; $display("[TB] FAIL err_hold2 got=%b exp=11", dwait); end
    errInject = 1'b0; #1;
    checks++; if (dwait !== 2'b01 || ramstore !== 32'hCAFE) begin failures++; $display("[TB] FAIL err_retry got=%b/%h exp=01/cafe", dwait, ramstore); end
    @(negedge CLK);
    clearInputs(); #1;
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("[TB] FAIL err_done got=%0d exp=IDLE", dut.state_q); end
  endtask

  task automatic test_drop;
    @(negedge CLK);
    iREN[0] = 1'b1; iaddr[0] = 32'h500;
    @(negedge CLK);
    @(negedge CLK); #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h500) begin failures++; $display("[TB] FAIL drop_pre got=%b/%h exp=1/500", ramREN, ramaddr); end
    iREN[0] = 1'b0; #1;
    checks++; if (ramREN !== 1'b0) begin failures++; $display("[TB] FAIL drop_strobe got=%b exp=0", ramREN); end
    @(negedge CLK); #1;
    checks++; if (dut.state_q !== IDLE || ramREN !== 1'b0) begin failures++; $display("[TB] FAIL drop_idle got=%0d/%b exp=IDLE/0", dut.state_q, ramREN); end
    clearInputs();
  endtask

  task automatic test_reset_mid;
    @(negedge CLK);
    dREN[0] = 1'b1; cctrans[0] = 1'b1; daddr[0] = 32'h100;
    repeat (5) @(negedge CLK);
    daddr[0] = 32'h104; #1;
    checks++; if (dut.state_q !== LOAD2 || ramREN !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_pre got=%0d/%b exp=LOAD2/1", dut.state_q, ramREN); end
    #1 nRST = 1'b0; #1;
    checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin failures++; $display("[TB] FAIL rstmid_drop got=%b/%b exp=0/11", ramREN, dwait); end
    checks++; if (dut.state_q !== IDLE) begin failures++; $display("[TB] FAIL rstmid_state got=%0d exp=IDLE", dut.state_q); end
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK); #1;
    checks++; if (dut.state_q !== ARB) begin failures++; $display("[TB] FAIL rstmid_arb got=%0d exp=ARB", dut.state_q); end
    @(negedge CLK); #1;
    checks++; if (ccwait !== 2'b10 || ccsnoopaddr[1] !== 32'h104) begin failures++; $display("[TB] FAIL rstmid_snoop got=%b/%h exp=10/104", ccwait, ccsnoopaddr[1]); end
    clearInputs();
    @(negedge CLK); #1;
    checks++; if (dut.state_q !== IDLE || ramREN !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_done got=%0d/%b exp=IDLE/0", dut.state_q, ramREN); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_dirty_hit();
    test_contention();
    test_eviction();
    test_ram_error();
    test_drop();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
